// File: rtl/alu_result_display.sv
// alu_result_display: double-dabble conversion of the ALU result onto a 4-digit multiplexed 7-seg display
module alu_result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] f,
    input  logic       cout,
    output logic       busy,
    output logic       done,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t        state;
    logic [7:0]    sr;
    logic [11:0]   bcd;
    logic [11:0]   adj;
    logic [2:0]    cnt;
    logic          flag;
    logic [11:0]   disp;
    logic          dflag;
    logic [RW-1:0] rcnt;
    logic [1:0]    idx;
    logic [6:0]    s0, s1, s2, s3;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = BLANK;
        endcase
    endfunction

    assign adj = {bcd[11:8] >= 4'd5 ? bcd[11:8] + 4'd3 : bcd[11:8],
                  bcd[7:4]  >= 4'd5 ? bcd[7:4]  + 4'd3 : bcd[7:4],
                  bcd[3:0]  >= 4'd5 ? bcd[3:0]  + 4'd3 : bcd[3:0]};

    // Capture, eight add-3/shift steps, then commit to the display in one go
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sr    <= '0;
            bcd   <= '0;
            cnt   <= '0;
            flag  <= 1'b0;
            disp  <= '0;
            dflag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (load) begin
                    sr    <= f;
                    flag  <= cout;
                    bcd   <= '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= CONVERT;
                end
                CONVERT: begin
                    {bcd, sr} <= {adj[10:0], sr, 1'b0};
                    cnt       <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        done  <= 1'b1;
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    disp  <= bcd;
                    dflag <= flag;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running refresh divider; the digit index steps on each wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt <= '0;
            idx  <= '0;
        end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
            rcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end

    assign s0  = seg7(disp[3:0]);
    assign s1  = disp[11:4] == 8'd0 ? BLANK : seg7(disp[7:4]);
    assign s2  = disp[11:8] == 4'd0 ? BLANK : seg7(disp[11:8]);
    assign s3  = dflag ? seg7(4'd1) : BLANK;
    assign seg = idx == 2'd0 ? s0 : idx == 2'd1 ? s1 : idx == 2'd2 ? s2 : s3;
    assign an  = ~(4'b0001 << idx);
    assign dp  = 1'b1;
endmodule
